// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: stall cause codes and
// the default register index width.
package hazard_pkg;

   localparam int DEF_REG_ADDR_W = 5;

   typedef enum logic [2:0] {
      NONE       = 3'd0,
      LOAD_USE   = 3'd1,
      BRANCH_DEP = 3'd2,
      MEM_FREEZE = 3'd3,
      REDIRECT   = 3'd4
   } cause_e;

endpackage

// File: rtl/hazard_dep_match.sv
// Compares one destination register against all ID source operands.
// Ports: rs/rs_used (packed sources + valids), rd (destination), hit (any-match).
module hazard_dep_match
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int NUM_SRC    = 2
) (
   input  logic [NUM_SRC*REG_ADDR_W-1:0] rs,
   input  logic [NUM_SRC-1:0]            rs_used,
   input  logic [REG_ADDR_W-1:0]         rd,
   output logic                          hit
);

   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (rs_used[i] && (rs[i*REG_ADDR_W +: REG_ADDR_W] == rd))
            hit = 1'b1;
      end
      // x0 is hardwired to zero and can never carry a hazard
      if (rd == '0)
         hit = 1'b0;
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use / branch-dependency stalls with a
// multi-cycle counter, dmem-busy pipe freeze and EX-redirect front-end flush.
// Ports: ID sources, EX/MEM destinations and control in; PC/IF-ID enables,
// IF-ID/ID-EX flushes, pipe_freeze and stall_cause out.
// Optional: define HAZARD_PERF_CNT_EN for stall_cycles/bubble_cnt counters.
module hazard_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int NUM_SRC    = 2,
   parameter int LOAD_LAT   = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
   input  logic [NUM_SRC-1:0]            id_rs_used,
   input  logic                          id_is_branch,
   input  logic [REG_ADDR_W-1:0]         ex_rd,
   input  logic [REG_ADDR_W-1:0]         mem_rd,
   input  logic                          ex_memread,
   input  logic                          ex_regwrite,
   input  logic                          mem_memread,
   input  logic                          ex_redirect,
   input  logic                          dmem_busy,
   output logic                          pc_write,
   output logic                          if_id_write,
   output logic                          id_ex_flush,
   output logic                          if_id_flush,
   output logic                          pipe_freeze,
`ifdef HAZARD_PERF_CNT_EN
   output logic [31:0]                   stall_cycles,
   output logic [31:0]                   bubble_cnt,
`endif
   output logic [2:0]                    stall_cause
);

   // Holds stall lengths up to LOAD_LAT+1
   localparam int CNT_W = $clog2(LOAD_LAT + 2);

   logic             ex_hit;
   logic             mem_hit;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] len;
   cause_e           cause_q;
   cause_e           cause_nxt;
   cause_e           det_cause;
   cause_e           cause_o;

   hazard_dep_match #(
      .REG_ADDR_W (REG_ADDR_W),
      .NUM_SRC    (NUM_SRC)
   ) u_ex_match (
      .rs      (id_rs),
      .rs_used (id_rs_used),
      .rd      (ex_rd),
      .hit     (ex_hit)
   );

   hazard_dep_match #(
      .REG_ADDR_W (REG_ADDR_W),
      .NUM_SRC    (NUM_SRC)
   ) u_mem_match (
      .rs      (id_rs),
      .rs_used (id_rs_used),
      .rd      (mem_rd),
      .hit     (mem_hit)
   );

   // Required stall length for the instruction currently in ID.
   // A branch compares in ID, so it needs the value one cycle earlier.
   always_comb begin
      len       = '0;
      det_cause = NONE;
      if (ex_memread && ex_hit) begin
         len       = CNT_W'(LOAD_LAT) + CNT_W'(id_is_branch);
         det_cause = LOAD_USE;
      end else if (mem_memread && mem_hit) begin
         len       = CNT_W'(LOAD_LAT - 1) + CNT_W'(id_is_branch);
         det_cause = LOAD_USE;
      end else if (id_is_branch && ex_regwrite && ex_hit) begin
         len       = CNT_W'(1);
         det_cause = BRANCH_DEP;
      end
   end

   always_comb begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      id_ex_flush = 1'b0;
      if_id_flush = 1'b0;
      pipe_freeze = 1'b0;
      cause_o     = NONE;
      cnt_nxt     = cnt;
      cause_nxt   = cause_q;
      if (!rst_n) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
      end else if (dmem_busy) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         pipe_freeze = 1'b1;
         cause_o     = MEM_FREEZE;
      end else if (ex_redirect) begin
         // Wrong-path instruction in ID: its pending stall is moot
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         cause_o     = REDIRECT;
         cnt_nxt     = '0;
         cause_nxt   = NONE;
      end else if (cnt != '0) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
         cause_o     = cause_q;
         cnt_nxt     = cnt - CNT_W'(1);
         if (cnt == CNT_W'(1))
            cause_nxt = NONE;
      end else if (len != '0) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
         cause_o     = det_cause;
         cnt_nxt     = len - CNT_W'(1);
         cause_nxt   = (len == CNT_W'(1)) ? NONE : det_cause;
      end
   end

   assign stall_cause = cause_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         cause_q <= NONE;
      end else begin
         cnt     <= cnt_nxt;
         cause_q <= cause_nxt;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         bubble_cnt   <= '0;
      end else begin
         if (!pc_write && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 32'd1;
         if (id_ex_flush && (bubble_cnt != '1))
            bubble_cnt <= bubble_cnt + 32'd1;
      end
   end
`endif

endmodule
